// File: rtl/mux_rr_sel_arbiter.sv
// Purpose: round-robin arbiter producing the 2-bit select (and one-hot grant) for a 4:1 data mux.
// Latency: 1 cycle from req to registered gnt/sel/valid; hand-off between grants has no idle bubble.
// Backpressure: none; req is level-sensitive and a grant is forcibly released after HOLD_MAX cycles.
module mux_rr_sel_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hcnt;

    logic [2:0] pick_idle;
    logic [2:0] pick_rel;
    logic [1:0] rel_start;
    logic       release_now;

    // Cyclic first-set search starting at 'start'; returns {found, index}.
    // Walking the offsets from far to near lets the nearest set bit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate winners for both arbitration cases and the release decision for the current holder.
    // When a grant is active sel always names the holder, so it doubles as g.
    always_comb begin
        rel_start   = sel + 2'd1;
        pick_idle   = rr_pick(req, ptr);
        pick_rel    = rr_pick(req, rel_start);
        release_now = !req[sel] || (hcnt == 8'(HOLD_MAX - 1));
    end

    // Arbiter FSM with registered outputs; reset overrides everything, including an active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            hcnt  <= 8'd0;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[2]) begin
                        gnt   <= 4'b0001 << pick_idle[1:0];
                        sel   <= pick_idle[1:0];
                        valid <= 1'b1;
                        hcnt  <= 8'd0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // Released channel drops to lowest priority; the search wraps back to it last.
                        ptr <= rel_start;
                        if (pick_rel[2]) begin
                            gnt  <= 4'b0001 << pick_rel[1:0];
                            sel  <= pick_rel[1:0];
                            hcnt <= 8'd0;
                        end else begin
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Bench for mux_rr_sel_arbiter: three instances (HOLD_MAX 8, 4, 1) share clk/rst/req.
// A reference model tracks owner / cycles-owned / priority start per instance.
module tb_mux_rr_sel_arbiter;

    localparam int HOLDS [3] = '{8, 4, 1};

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel_a   [3];
    logic [3:0] gnt_a   [3];
    logic       valid_a [3];

    int cmp_cnt = 0;
    int err_cnt = 0;

    mux_rr_sel_arbiter #(.HOLD_MAX(8)) u_h8 (
        .clk(clk), .rst(rst), .req(req), .sel(sel_a[0]), .gnt(gnt_a[0]), .valid(valid_a[0])
    );
    mux_rr_sel_arbiter #(.HOLD_MAX(4)) u_h4 (
        .clk(clk), .rst(rst), .req(req), .sel(sel_a[1]), .gnt(gnt_a[1]), .valid(valid_a[1])
    );
    mux_rr_sel_arbiter #(.HOLD_MAX(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req), .sel(sel_a[2]), .gnt(gnt_a[2]), .valid(valid_a[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_own [3] = '{-1, -1, -1};  // owning channel, -1 when nobody holds a grant
    int m_age [3] = '{0, 0, 0};     // cycles the current owner has held the grant
    int m_ptr [3] = '{0, 0, 0};     // where the next idle search starts
    int m_sel [3] = '{0, 0, 0};     // last granted channel
    int m_w;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_own[k] = -1; m_age[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
            end else if (m_own[k] < 0) begin
                m_w = first_from(req, m_ptr[k]);
                if (m_w >= 0) begin
                    m_own[k] = m_w; m_age[k] = 1; m_sel[k] = m_w;
                end
            end else if (req[m_own[k]] && m_age[k] < HOLDS[k]) begin
                m_age[k] = m_age[k] + 1;
            end else begin
                m_ptr[k] = (m_own[k] + 1) % 4;
                m_w = first_from(req, m_ptr[k]);
                if (m_w >= 0) begin
                    m_own[k] = m_w; m_age[k] = 1; m_sel[k] = m_w;
                end else begin
                    m_own[k] = -1;
                end
            end
        end
    end

    function automatic logic [3:0] model_gnt(input int own);
        logic [3:0] one;
        one = 4'b0001;
        return (own < 0) ? 4'b0000 : (one << own);
    endfunction

    // ---------------- tests ----------------
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cmp_cnt++;
            if ({sel_a[k], gnt_a[k], valid_a[k]} !== 7'b0) begin
                err_cnt++;
                $display("FAIL reset_state inst=%0d got sel=%0d gnt=%b valid=%b want 0/0000/0",
                         k, sel_a[k], gnt_a[k], valid_a[k]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({sel_a[0], gnt_a[0], valid_a[0]} !== 7'b0) begin
                err_cnt++;
                $display("FAIL idle_no_req cyc=%0d got sel=%0d gnt=%b valid=%b want 0/0000/0",
                         c, sel_a[0], gnt_a[0], valid_a[0]);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        @(negedge clk);
        cmp_cnt++;
        if ({sel_a[0], gnt_a[0], valid_a[0]} !== {2'd2, 4'b0100, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_grant got sel=%0d gnt=%b valid=%b want 2/0100/1",
                     sel_a[0], gnt_a[0], valid_a[0]);
        end
        req = 4'b0000;
        @(negedge clk);
        cmp_cnt++;
        if ({sel_a[0], gnt_a[0], valid_a[0]} !== {2'd2, 4'b0000, 1'b0}) begin
            err_cnt++;
            $display("FAIL single_drop got sel=%0d gnt=%b valid=%b want 2/0000/0",
                     sel_a[0], gnt_a[0], valid_a[0]);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            exp_g = 4'b0001 << (((c - 1) / 8) % 4);
            cmp_cnt++;
            if (gnt_a[0] !== exp_g || valid_a[0] !== 1'b1) begin
                err_cnt++;
                $display("FAIL rotate_h8 cyc=%0d got gnt=%b valid=%b want %b/1",
                         c, gnt_a[0], valid_a[0], exp_g);
            end
        end
    endtask

    task automatic test_hold1_scan();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_g = 4'b0001 << ((c - 1) % 4);
            cmp_cnt++;
            if (gnt_a[2] !== exp_g || sel_a[2] !== 2'((c - 1) % 4)) begin
                err_cnt++;
                $display("FAIL scan_h1 cyc=%0d got gnt=%b sel=%0d want %b/%0d",
                         c, gnt_a[2], sel_a[2], exp_g, (c - 1) % 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (gnt_a[0] !== 4'b0010) begin
            err_cnt++;
            $display("FAIL handoff_hold got gnt=%b want 0010", gnt_a[0]);
        end
        req = 4'b0001;
        @(negedge clk);
        cmp_cnt++;
        if ({sel_a[0], gnt_a[0], valid_a[0]} !== {2'd0, 4'b0001, 1'b1}) begin
            err_cnt++;
            $display("FAIL handoff_wrap got sel=%0d gnt=%b valid=%b want 0/0001/1",
                     sel_a[0], gnt_a[0], valid_a[0]);
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            for (int k = 1; k < 3; k++) begin
                cmp_cnt++;
                if (gnt_a[k] !== 4'b0100 || valid_a[k] !== 1'b1 || sel_a[k] !== 2'd2) begin
                    err_cnt++;
                    $display("FAIL sole_regrant inst=%0d cyc=%0d got gnt=%b valid=%b sel=%0d want 0100/1/2",
                             k, c, gnt_a[k], valid_a[k], sel_a[k]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        cmp_cnt++;
        if (gnt_a[0] !== 4'b1000) begin
            err_cnt++;
            $display("FAIL rstmid_pre got gnt=%b want 1000", gnt_a[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({sel_a[0], gnt_a[0], valid_a[0]} !== 7'b0) begin
            err_cnt++;
            $display("FAIL rstmid_clear got sel=%0d gnt=%b valid=%b want 0/0000/0",
                     sel_a[0], gnt_a[0], valid_a[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({sel_a[0], gnt_a[0], valid_a[0]} !== {2'd3, 4'b1000, 1'b1}) begin
            err_cnt++;
            $display("FAIL rstmid_regrant got sel=%0d gnt=%b valid=%b want 3/1000/1",
                     sel_a[0], gnt_a[0], valid_a[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                eg = model_gnt(m_own[k]);
                cmp_cnt++;
                if (gnt_a[k] !== eg || valid_a[k] !== (m_own[k] >= 0) || sel_a[k] !== 2'(m_sel[k])) begin
                    err_cnt++;
                    $display("FAIL random inst=%0d cyc=%0d got gnt=%b valid=%b sel=%0d want %b/%0d/%0d",
                             k, c, gnt_a[k], valid_a[k], sel_a[k], eg, m_own[k] >= 0, m_sel[k]);
                end
                cmp_cnt++;
                if (valid_a[k] !== (|gnt_a[k]) || (valid_a[k] && !gnt_a[k][sel_a[k]]) ||
                    ($countones(gnt_a[k]) > 1)) begin
                    err_cnt++;
                    $display("FAIL invariant inst=%0d cyc=%0d got gnt=%b valid=%b sel=%0d want onehot, valid=|gnt, gnt[sel]",
                             k, c, gnt_a[k], valid_a[k], sel_a[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_rotate();
        test_hold1_scan();
        test_back_to_back();
        test_sole();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
